// File: rtl/session_sequencer.sv
// session_sequencer: game session controller.
// Walks IDLE -> COUNTDOWN (3,2,1) -> PLAY -> RESULTS -> IDLE, pulsing
// player_rst on each accepted start and done when the results screen expires.
// All counters advance only on tick_i. A start_i in any state restarts the
// session immediately.
// Optional feature: define SESSION_PAUSE_EN to enable a pause button that
// toggles between PLAY and PAUSE on each press.
module session_sequencer #(
  parameter int COUNT_TICKS  = 60,
  parameter int RESULT_TICKS = 180
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  song_i,
  input  logic        tick_i,
  input  logic        pause_btn_i,
  input  logic        song_end_i,
  output logic [2:0]  phase_o,
  output logic [1:0]  song_sel_o,
  output logic        player_rst_o,
  output logic        play_en_o,
  output logic [1:0]  count_digit_o,
  output logic [15:0] elapsed_o,
  output logic        done_o
);

  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] COUNTDOWN = 3'b001;
  localparam logic [2:0] PLAY      = 3'b010;
  localparam logic [2:0] PAUSE     = 3'b011;
  localparam logic [2:0] RESULTS   = 3'b100;

  // The tick counter is shared between the countdown and results screens,
  // so it is sized for the larger of the two terminal counts.
  localparam logic [15:0] COUNT_LAST  = 16'(COUNT_TICKS - 1);
  localparam logic [15:0] RESULT_LAST = 16'(RESULT_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  song_sel_q, song_sel_d;
  logic        player_rst_q, player_rst_d;
  logic        play_en_q, play_en_d;
  logic [1:0]  count_digit_q, count_digit_d;
  logic [15:0] elapsed_q, elapsed_d;
  logic        done_q, done_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;

`ifdef SESSION_PAUSE_EN
  logic pause_q;
  logic pause_edge;

  // Remember last cycle's button level so a held press yields one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_btn_i;
    end
  end

  assign pause_edge = pause_btn_i & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause_btn_i;
`endif

  // Next-state logic: start overrides everything, otherwise per-state rules.
  always_comb begin
    state_d       = state_q;
    song_sel_d    = song_sel_q;
    player_rst_d  = 1'b0;
    count_digit_d = count_digit_q;
    elapsed_d     = elapsed_q;
    done_d        = 1'b0;
    tick_cnt_d    = tick_cnt_q;

    if (start_i) begin
      state_d       = COUNTDOWN;
      song_sel_d    = song_i;
      player_rst_d  = 1'b1;
      count_digit_d = 2'd3;
      elapsed_d     = 16'd0;
      tick_cnt_d    = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        COUNTDOWN: begin
          if (tick_i) begin
            if (tick_cnt_q == COUNT_LAST) begin
              tick_cnt_d = 16'd0;
              if (count_digit_q == 2'd1) begin
                state_d       = PLAY;
                count_digit_d = 2'd0;
              end else begin
                count_digit_d = count_digit_q - 2'd1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 16'd1;
            end
          end
        end

        PLAY: begin
          if (tick_i && (elapsed_q != 16'hFFFF)) begin
            elapsed_d = elapsed_q + 16'd1;
          end
          if (song_end_i) begin
            state_d    = RESULTS;
            tick_cnt_d = 16'd0;
          end
`ifdef SESSION_PAUSE_EN
          else if (pause_edge) begin
            state_d = PAUSE;
          end
`endif
        end

`ifdef SESSION_PAUSE_EN
        PAUSE: begin
          if (song_end_i) begin
            state_d    = RESULTS;
            tick_cnt_d = 16'd0;
          end else if (pause_edge) begin
            state_d = PLAY;
          end
        end
`endif

        RESULTS: begin
          if (tick_i) begin
            if (tick_cnt_q == RESULT_LAST) begin
              state_d    = IDLE;
              done_d     = 1'b1;
              tick_cnt_d = 16'd0;
            end else begin
              tick_cnt_d = tick_cnt_q + 16'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    play_en_d = (state_d == PLAY);
  end

  // Session state registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      song_sel_q    <= 2'd0;
      player_rst_q  <= 1'b0;
      play_en_q     <= 1'b0;
      count_digit_q <= 2'd0;
      elapsed_q     <= 16'd0;
      done_q        <= 1'b0;
      tick_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      song_sel_q    <= song_sel_d;
      player_rst_q  <= player_rst_d;
      play_en_q     <= play_en_d;
      count_digit_q <= count_digit_d;
      elapsed_q     <= elapsed_d;
      done_q        <= done_d;
      tick_cnt_q    <= tick_cnt_d;
    end
  end

  assign phase_o       = state_q;
  assign song_sel_o    = song_sel_q;
  assign player_rst_o  = player_rst_q;
  assign play_en_o     = play_en_q;
  assign count_digit_o = count_digit_q;
  assign elapsed_o     = elapsed_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_session_sequencer.sv
// tb_session_sequencer: scoreboard bench for session_sequencer.
// Stimulus pushes the expected output snapshot for every visible change;
// a negedge monitor pops and compares whenever phase, song_sel, count_digit,
// play_en, player_rst or done changes. Build with SESSION_PAUSE_EN to
// exercise the pause path.
module tb_session_sequencer;

  typedef struct packed {
    logic [2:0]  ph;
    logic [1:0]  ss;
    logic [1:0]  cd;
    logic        pe;
    logic        pr;
    logic        dn;
    logic [15:0] el;
  } snap_t;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [1:0]  song;
  logic        tick;
  logic        pauseBtn;
  logic        songEnd;
  logic [2:0]  phase;
  logic [1:0]  songSel;
  logic        playerRst;
  logic        playEn;
  logic [1:0]  countDigit;
  logic [15:0] elapsed;
  logic        done;

  snap_t expQ[$];
  int    total;
  int    bad;
  int    reqCount;
  logic  monEn;
  logic  endReq;
  logic  endDone;

  session_sequencer #(
    .COUNT_TICKS  (2),
    .RESULT_TICKS (3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .start_i       (start),
    .song_i        (song),
    .tick_i        (tick),
    .pause_btn_i   (pauseBtn),
    .song_end_i    (songEnd),
    .phase_o       (phase),
    .song_sel_o    (songSel),
    .player_rst_o  (playerRst),
    .play_en_o     (playEn),
    .count_digit_o (countDigit),
    .elapsed_o     (elapsed),
    .done_o        (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: compares on every visible output change or explicit request.
  initial begin : monitor
    snap_t cur;
    snap_t prev;
    snap_t want;
    logic  primed;
    logic  doCheck;
    int    seenReq;
    total   = 0;
    bad     = 0;
    endDone = 1'b0;
    primed  = 1'b0;
    seenReq = 0;
    prev    = '0;
    forever begin
      @(negedge clk);
      if (monEn) begin
        cur = {phase, songSel, countDigit, playEn, playerRst, done, elapsed};
        doCheck = 1'b0;
        if (primed) begin
          doCheck = (cur.ph != prev.ph) || (cur.ss != prev.ss) ||
                    (cur.cd != prev.cd) || (cur.pe != prev.pe) ||
                    (cur.pr != prev.pr) || (cur.dn != prev.dn);
        end
        if (reqCount != seenReq) begin
          seenReq = reqCount;
          doCheck = 1'b1;
        end
        if (doCheck) begin
          total++;
          if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_event t=%0t got ph=%0d ss=%0d cd=%0d pe=%0b pr=%0b dn=%0b el=%0d",
                     $time, cur.ph, cur.ss, cur.cd, cur.pe, cur.pr, cur.dn, cur.el);
          end else begin
            want = expQ.pop_front();
            if (cur !== want) begin
              bad++;
              $display("[TB] FAIL event t=%0t got ph=%0d ss=%0d cd=%0d pe=%0b pr=%0b dn=%0b el=%0d want ph=%0d ss=%0d cd=%0d pe=%0b pr=%0b dn=%0b el=%0d",
                       $time, cur.ph, cur.ss, cur.cd, cur.pe, cur.pr, cur.dn, cur.el,
                       want.ph, want.ss, want.cd, want.pe, want.pr, want.dn, want.el);
            end
          end
        end
        if (endReq && !endDone) begin
          total++;
          if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL missing_events got pending=%0d want pending=0", expQ.size());
          end
          endDone = 1'b1;
        end
        prev   = cur;
        primed = 1'b1;
      end
    end
  end

  // Queue one expected output snapshot.
  task automatic expectEvent(input logic [2:0] ph, input logic [1:0] ss,
                             input logic [1:0] cd, input logic pe,
                             input logic pr, input logic dn,
                             input logic [15:0] el);
    snap_t s;
    s = {ph, ss, cd, pe, pr, dn, el};
    expQ.push_back(s);
  endtask

  // Drive one cycle of inputs; pulses are cleared just after the edge.
  task automatic applyStimulus(input logic st, input logic [1:0] sg,
                               input logic tk, input logic se);
    start   = st;
    song    = sg;
    tick    = tk;
    songEnd = se;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tick    = 1'b0;
    songEnd = 1'b0;
  endtask

  // Force the monitor to compare the current outputs against the queue head.
  task automatic checkOutput();
    reqCount++;
    @(negedge clk);
    #1;
  endtask

  // Accepted start: COUNTDOWN with digit 3 and a one-cycle player reset.
  task automatic startSession(input logic [1:0] sg);
    expectEvent(3'd1, sg, 2'd3, 1'b0, 1'b1, 1'b0, 16'd0);
    applyStimulus(1'b1, sg, 1'b0, 1'b0);
    expectEvent(3'd1, sg, 2'd3, 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Six ticks with two ticks per digit: 3,3,2,2,1,1 then PLAY.
  task automatic runCountdown(input logic [1:0] sg);
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) expectEvent(3'd1, sg, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0);
      if (i == 4) expectEvent(3'd1, sg, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0);
      if (i == 6) expectEvent(3'd2, sg, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  // Directed scenario sequence.
  initial begin
    rstN     = 1'b1;
    start    = 1'b0;
    song     = 2'd0;
    tick     = 1'b0;
    pauseBtn = 1'b0;
    songEnd  = 1'b0;
    monEn    = 1'b0;
    endReq   = 1'b0;
    reqCount = 0;
    #2;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    expectEvent(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    monEn = 1'b1;
    checkOutput();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] session 1: full countdown, play, results");
    startSession(2'd2);
    runCountdown(2'd2);
    ticks(5);
    expectEvent(3'd4, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd5);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    ticks(2);
    expectEvent(3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 16'd5);
    ticks(1);
    expectEvent(3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd5);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    $display("[TB] idle ignores tick, pause and song_end");
    pauseBtn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    pauseBtn = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

    $display("[TB] session 2: song_end beats pause, abort from results");
    startSession(2'd1);
    runCountdown(2'd1);
    ticks(2);
    expectEvent(3'd4, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd2);
    pauseBtn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    ticks(1);
    pauseBtn = 1'b0;
    startSession(2'd3);
    runCountdown(2'd3);
    ticks(3);

    $display("[TB] reset mid-play");
    expectEvent(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] session 3: start right after reset release");
    startSession(2'd2);
    runCountdown(2'd2);
    ticks(2);
`ifdef SESSION_PAUSE_EN
    $display("[TB] pause held with ticks, then resume");
    expectEvent(3'd3, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd2);
    pauseBtn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 2'd0, (i < 4), 1'b0);
    pauseBtn = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    expectEvent(3'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 16'd2);
    pauseBtn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    pauseBtn = 1'b0;
`else
    $display("[TB] pause button ignored in play");
    pauseBtn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    pauseBtn = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
`endif
    ticks(1);
    expectEvent(3'd4, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    ticks(2);
    expectEvent(3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 16'd3);
    ticks(1);
    expectEvent(3'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);

    repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    endReq = 1'b1;
    for (int i = 0; i < 5 && !endDone; i++) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/session_sequencer.md
SESSION_SEQUENCER -- requirements
Module: session_sequencer

Interface
REQ-001 Parameter COUNT_TICKS, default 60, ticks per countdown digit (legal range 1..255).
REQ-002 Parameter RESULT_TICKS, default 180, ticks the results screen is held (legal range 1..65535).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 start  input  1  one-cycle request to begin a session (driven by the menu's component-reset pulse).
REQ-006 song  input  2  song index, sampled only when start is accepted.
REQ-007 tick  input  1  one-cycle frame enable; the only time base for all counters.
REQ-008 pause_btn  input  1  level from the debounced pause button.
REQ-009 song_end  input  1  one-cycle pulse from the note player when the last note has passed.
REQ-010 phase  output  3  current state encoding.
REQ-011 song_sel  output  2  latched song index for the active session.
REQ-012 player_rst  output  1  one-cycle pulse that restarts the note player and scorer.
REQ-013 play_en  output  1  high while notes advance and scoring is active.
REQ-014 count_digit  output  2  countdown digit to display (3, 2, 1); 0 outside COUNTDOWN.
REQ-015 elapsed  output  16  play ticks in the current session.
REQ-016 done  output  1  one-cycle pulse that returns the menu to song selection.

Function
REQ-017 The states SHALL be encoded as IDLE=000, COUNTDOWN=001, PLAY=010, PAUSE=011 and RESULTS=100, and phase SHALL equal the state register.
REQ-018 In IDLE, start SHALL move the block to COUNTDOWN on the next edge, latch song into song_sel, set count_digit=3, clear the tick counter and elapsed, and assert player_rst for exactly that one cycle.
REQ-019 A start seen in any non-IDLE state SHALL abort the session and apply the same actions as REQ-018, with no done pulse; start SHALL have priority over every other event.
REQ-020 In COUNTDOWN, each tick SHALL increment the tick counter; on the tick where the counter equals COUNT_TICKS-1, the counter SHALL clear and count_digit SHALL decrement, and when count_digit is 1 the block SHALL enter PLAY instead.
REQ-021 play_en SHALL be high only in PLAY, and SHALL be registered so it rises on the same edge that phase becomes PLAY.
REQ-022 In PLAY, each tick SHALL increment elapsed; elapsed SHALL saturate at 16'hFFFF and not wrap.
REQ-023 In PLAY, song_end SHALL enter RESULTS and clear the tick counter; if song_end and a pause edge occur in the same cycle, song_end SHALL win.
REQ-024 A pause edge SHALL be defined as pause_btn high in this cycle with a registered pause_btn low in the previous cycle; a held button SHALL produce only one edge.
REQ-025 In RESULTS, each tick SHALL increment the tick counter; on the tick where it equals RESULT_TICKS-1, the block SHALL return to IDLE and pulse done high for exactly one cycle.
REQ-026 song_end outside PLAY and PAUSE, and tick or pause_btn in IDLE, SHALL be ignored.
REQ-027 song_sel SHALL hold its value through RESULTS and IDLE until the next accepted start.

Reset
REQ-028 While reset is low: state=IDLE, song_sel=0, player_rst=0, play_en=0, count_digit=0, elapsed=0, done=0, tick counter=0 and registered pause_btn=0.
REQ-029 Reset asserted mid-session SHALL abandon the session without issuing done.
REQ-030 Reset release SHALL be treated as synchronous to clk, and the first start after release SHALL be honoured.

Configuration
REQ-031 With macro SESSION_PAUSE_EN defined, a pause edge in PLAY SHALL enter PAUSE, and a pause edge in PAUSE SHALL return to PLAY.
REQ-032 In PAUSE (with SESSION_PAUSE_EN), elapsed SHALL freeze, tick SHALL be ignored and song_end SHALL enter RESULTS.
REQ-033 Without SESSION_PAUSE_EN, pause_btn SHALL be ignored, PAUSE SHALL be unreachable, and the pause-edge register SHALL be removed.

Verification (COUNT_TICKS=2, RESULT_TICKS=3)
REQ-034 Bench: reset low then high, start with song=2 -> next cycle phase=001, song_sel=2, player_rst=1 for one cycle, count_digit=3.
REQ-035 Bench: 6 ticks after start -> count_digit steps 3,3,2,2,1 and phase=010 with play_en=1 after the 6th tick.
REQ-036 Bench: in PLAY, 5 ticks then song_end, then 3 ticks -> elapsed=5, phase=100, then one done pulse and phase=000.
REQ-037 Bench: song_end and pause edge in the same cycle during PLAY -> phase=100, never 011.
REQ-038 Bench (with SESSION_PAUSE_EN): pause held 10 cycles with 4 ticks -> phase=011, elapsed unchanged; release and press again -> phase=010.
REQ-039 Bench: start while in RESULTS, and separately reset low while in PLAY -> COUNTDOWN restart (or IDLE for reset) with done never asserted.
